csa_accum_issuer: RTL

//  Carry-save accumulator that produces the redundant column pairs consumed by adder_final.

---
 rtl/csa_pkg.sv | 35 +++
 rtl/csa32_row.sv | 29 ++
 rtl/csa_accum_issuer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pkg
//  Purpose  : Shared types, default widths and the column-pair packing
//             helper for the carry-save accumulator issuer.
//  Revision : 1.0 - initial release
// ============================================================================
package csa_pkg;

    localparam int CSA_IN_W      = 12;
    localparam int CSA_OUT_W     = 14;
    localparam int CSA_MAX_TERMS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } csa_state_t;

    // Interleave sum and carry vectors: bit 2k = S[k], bit 2k+1 = C[k].
    function automatic logic [2*CSA_OUT_W-1:0] pack_cols(
        input logic [CSA_OUT_W-1:0] s,
        input logic [CSA_OUT_W-1:0] c
    );
        logic [2*CSA_OUT_W-1:0] p;
        p = '0;
        for (int k = 0; k < CSA_OUT_W; k++) begin
            p[2*k]   = s[k];
            p[2*k+1] = c[k];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa32_row.sv
`default_nettype none
// ============================================================================
//  Module   : csa32_row
//  Purpose  : W-wide combinational 3:2 compressor row. The carry vector is
//             returned already shifted one column left; the majority of the
//             top column is dropped, so carry[0] is always 0.
//  Revision : 1.0 - initial release
// ============================================================================
module csa32_row #(
    parameter int W = 14
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] x,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    // Bitwise full-adder row: sum in place, majority moved up one column.
    always_comb begin
        sum   = a ^ b ^ x;
        carry = '0;
        for (int k = 1; k < W; k++) begin
            carry[k] = (a[k-1] & b[k-1]) | (a[k-1] & x[k-1]) | (b[k-1] & x[k-1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/csa_accum_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accum_issuer
//  Purpose  : Carry-save accumulator between the PE multiplier array and the
//             final adder. One 3:2 row per accepted beat; on the closing beat
//             the {C[k],S[k]} column pairs are held under valid/ready.
//  Options  : CSA_ACC_REF_SUM_EN - when defined, ref_sum presents the
//             resolved S+C while col_valid is high; otherwise ref_sum is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_accum_issuer
    import csa_pkg::*;
#(
    parameter int IN_W      = CSA_IN_W,
    parameter int OUT_W     = CSA_OUT_W,
    parameter int MAX_TERMS = CSA_MAX_TERMS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_last,
    output logic                 col_valid,
    input  logic                 col_ready,
    output logic [2*OUT_W-1:0]   col_pairs,
    output logic                 term_ovf,
    output logic [OUT_W-1:0]     ref_sum
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

    csa_state_t        state;
    csa_state_t        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [OUT_W-1:0]  s_q;
    logic [OUT_W-1:0]  c_q;
    logic [OUT_W-1:0]  x_ext;
    logic [OUT_W-1:0]  row_sum;
    logic [OUT_W-1:0]  row_carry;
    logic [2*OUT_W-1:0] packed_cols;
    logic              accept;
    logic              at_max;
    logic              release_cols;

    assign x_ext        = OUT_W'(in_data);
    assign cnt_inc      = cnt + CNT_W'(1);
    assign at_max       = (cnt_inc == CNT_MAX);
    assign in_ready     = (state != HOLD) & ~rst;
    assign accept       = in_valid & in_ready;
    assign col_valid    = (state == HOLD);
    assign release_cols = col_valid & col_ready;

    csa32_row #(.W(OUT_W)) u_row (
        .a     (s_q),
        .b     (c_q),
        .x     (x_ext),
        .sum   (row_sum),
        .carry (row_carry)
    );

    if (OUT_W == CSA_OUT_W) begin : g_pack_fn
        assign packed_cols = pack_cols(s_q, c_q);
    end else begin : g_pack_loop
        // Same interleave as pack_cols for non-default widths.
        always_comb begin
            packed_cols = '0;
            for (int k = 0; k < OUT_W; k++) begin
                packed_cols[2*k]   = s_q[k];
                packed_cols[2*k+1] = c_q[k];
            end
        end
    end

    assign col_pairs = col_valid ? packed_cols : '0;

`ifdef CSA_ACC_REF_SUM_EN
    assign ref_sum = col_valid ? (s_q + c_q) : '0;
`else
    assign ref_sum = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: close on last beat or full group, reopen on column handoff.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    state_nx = (in_last || at_max) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (col_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Running S/C, beat counter and the force-close pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            c_q      <= '0;
            cnt      <= '0;
            term_ovf <= 1'b0;
        end else begin
            term_ovf <= accept & ~in_last & at_max;
            if (release_cols) begin
                s_q <= '0;
                c_q <= '0;
                cnt <= '0;
            end else if (accept) begin
                s_q <= row_sum;
                c_q <= row_carry;
                cnt <= cnt_inc;
            end
        end
    end

endmodule
`default_nettype wire
